// File: rtl/led_panel_pkg.sv
// Shared types and constants for the LED panel command decoder and its frame buffer.
package led_panel_pkg;

    typedef enum logic [1:0] {
        S_CTRL,
        S_COL,
        S_ROW
    } state_e;

    localparam logic [3:0] OP_RGB  = 4'h0;
    localparam logic [3:0] OP_SET  = 4'h1;
    localparam logic [3:0] OP_CLR  = 4'h2;
    localparam logic [3:0] OP_CLS  = 4'h3;
    localparam logic [3:0] OP_FILL = 4'h4;

    localparam logic [7:0] RESYNC_BYTE = 8'hF5;

    localparam int FB_COLS = 16;
    localparam int FB_ROWS = 8;
    localparam int COL_W   = $clog2(FB_COLS);
    localparam int ROW_W   = $clog2(FB_ROWS);

    localparam logic [2:0] RGB_RESET = 3'b111;

endpackage

// File: rtl/led_fb_regs.sv
// 16x8 monochrome frame buffer: single-bit write, whole-array clear/fill, combinational column read.
module led_fb_regs
    import led_panel_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               wr_en,
    input  logic [COL_W-1:0]   wr_col,
    input  logic [ROW_W-1:0]   wr_row,
    input  logic               wr_val,
    input  logic               clr_all,
    input  logic               fill_all,
    input  logic [COL_W-1:0]   rd_col,
    output logic [FB_ROWS-1:0] rd_data
);

    logic [FB_COLS-1:0][FB_ROWS-1:0] mem_d, mem_q;

    // NOTE: default to the current contents first so no path leaves mem_d unassigned (no latch).
    always_comb begin
        mem_d = mem_q;
        if (clr_all) begin
            mem_d = '0;
        end else if (fill_all) begin
            mem_d = '1;
        end else if (wr_en) begin
            mem_d[wr_col][wr_row] = wr_val;
        end
    end

    // NOTE: the array is only 128 flops, so it is cleared by the async reset rather than left unreset
    // like a RAM; state is updated with non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_q <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_data = mem_q[rd_col];

endmodule

// File: rtl/led_cmd_decoder.sv
// Byte-stream command decoder owning the frame buffer and colour. Optional inter-byte timeout
// is enabled by defining LED_CMD_TIMEOUT_EN.
module led_cmd_decoder
    import led_panel_pkg::*;
`ifdef LED_CMD_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CLKS = 800
)
`endif
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         rx_byte,
    input  logic               rx_dv,
    input  logic [COL_W-1:0]   fb_col,
    output logic [FB_ROWS-1:0] fb_data,
    output logic [2:0]         rgb,
    output logic               busy,
    output logic               cmd_done,
    output logic               cmd_err
);

    state_e             state_d, state_q;
    logic               op_set_d, op_set_q;
    logic [COL_W-1:0]   col_d, col_q;
    logic [2:0]         rgb_d, rgb_q;
    logic               done_d, done_q;
    logic               err_d, err_q;
    logic               fb_wr, fb_clr, fb_fill;

`ifdef LED_CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CLKS);
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             expired;

    // A byte on the expiry cycle wins over the timeout.
    assign expired = (state_q != S_CTRL) && !rx_dv && (cnt_q == CNT_W'(TIMEOUT_CLKS - 1));
`endif

    always_comb begin
        state_d  = state_q;
        op_set_d = op_set_q;
        col_d    = col_q;
        rgb_d    = rgb_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        fb_wr    = 1'b0;
        fb_clr   = 1'b0;
        fb_fill  = 1'b0;

        if (rx_dv) begin
            unique case (state_q)
                S_CTRL: begin
                    if (rx_byte != RESYNC_BYTE) begin
                        unique case (rx_byte[7:4])
                            OP_RGB:  begin rgb_d = rx_byte[2:0]; done_d = 1'b1; end
                            OP_SET:  begin op_set_d = 1'b1; state_d = S_COL; end
                            OP_CLR:  begin op_set_d = 1'b0; state_d = S_COL; end
                            OP_CLS:  begin fb_clr  = 1'b1; done_d = 1'b1; end
                            OP_FILL: begin fb_fill = 1'b1; done_d = 1'b1; end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                S_COL: begin
                    state_d = S_CTRL;
                    if (rx_byte == RESYNC_BYTE) begin
                        state_d = S_CTRL;
                    end else if (rx_byte[7:4] != 4'h0) begin
                        err_d = 1'b1;
                    end else begin
                        col_d   = rx_byte[COL_W-1:0];
                        state_d = S_ROW;
                    end
                end
                S_ROW: begin
                    state_d = S_CTRL;
                    if (rx_byte == RESYNC_BYTE) begin
                        state_d = S_CTRL;
                    end else if (rx_byte > 8'h07) begin
                        err_d = 1'b1;
                    end else begin
                        fb_wr  = 1'b1;
                        done_d = 1'b1;
                    end
                end
                default: state_d = S_CTRL;
            endcase
        end
`ifdef LED_CMD_TIMEOUT_EN
        else if (expired) begin
            state_d = S_CTRL;
            err_d   = 1'b1;
        end

        if (rx_dv || state_d == S_CTRL) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_CTRL;
            op_set_q <= 1'b0;
            col_q    <= '0;
            rgb_q    <= RGB_RESET;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef LED_CMD_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_set_q <= op_set_d;
            col_q    <= col_d;
            rgb_q    <= rgb_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef LED_CMD_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    led_fb_regs u_fb (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_en    (fb_wr),
        .wr_col   (col_q),
        .wr_row   (rx_byte[ROW_W-1:0]),
        .wr_val   (op_set_q),
        .clr_all  (fb_clr),
        .fill_all (fb_fill),
        .rd_col   (fb_col),
        .rd_data  (fb_data)
    );

    assign rgb      = rgb_q;
    assign busy     = (state_q != S_CTRL);
    assign cmd_done = done_q;
    assign cmd_err  = err_q;

endmodule

// File: tb/tb_led_cmd_decoder.sv
// Scoreboard bench for led_cmd_decoder: stimulus queues expected pulses, a monitor pops and compares them.
module tb_led_cmd_decoder;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       rx_dv = 1'b0;
    logic [3:0] fb_col = 4'h0;
    logic [7:0] fb_data;
    logic [2:0] rgb;
    logic       busy, cmd_done, cmd_err;

    led_cmd_decoder dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_byte  (rx_byte),
        .rx_dv    (rx_dv),
        .fb_col   (fb_col),
        .fb_data  (fb_data),
        .rgb      (rgb),
        .busy     (busy),
        .cmd_done (cmd_done),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       is_err;
        logic [2:0] rgb;
    } exp_t;

    localparam int K_NONE = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    exp_t       exp_q[$];
    logic [7:0] fb_model [16];
    logic [2:0] rgb_model;
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: every pulse seen must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && (cmd_done || cmd_err)) begin
                check("pulse_exclusive", {31'd0, cmd_done & cmd_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b with empty queue at %0t",
                             cmd_done, cmd_err, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind_err", {31'd0, cmd_err}, {31'd0, e.is_err});
                    check("pulse_rgb", {29'd0, rgb}, {29'd0, e.rgb});
                    check("pulse_busy", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input int kind);
        exp_t e;
        if (kind != K_NONE) begin
            e.is_err = (kind == K_ERR);
            e.rgb    = rgb_model;
            exp_q.push_back(e);
        end
        @(negedge clk);
        rx_byte = b;
        rx_dv   = 1'b1;
        @(negedge clk);
        rx_dv   = 1'b0;
    endtask

    task automatic check_fb(input string name);
        for (int c = 0; c < 16; c++) begin
            fb_col = 4'(c);
            #1;
            check(name, {24'd0, fb_data}, {24'd0, fb_model[c]});
        end
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        check(name, exp_q.size(), 0);
    endtask

    task automatic model_reset();
        for (int c = 0; c < 16; c++) fb_model[c] = 8'h00;
        rgb_model = 3'b111;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_rgb", {29'd0, rgb}, 32'd7);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_pulses", {30'd0, cmd_done, cmd_err}, 32'd0);
        reset_n = 1'b1;
        check_fb("reset_fb");

        // Set and clear pixel (5,3).
        send(8'h10, K_NONE);
        check("busy_after_opcode", {31'd0, busy}, 32'd1);
        send(8'h05, K_NONE);
        fb_model[5] = 8'h08;
        send(8'h03, K_DONE);
        fb_col = 4'd5; #1;
        check("set_col5", {24'd0, fb_data}, 32'h08);
        drain("set_drain");
        send(8'h20, K_NONE);
        send(8'h05, K_NONE);
        fb_model[5] = 8'h00;
        send(8'h03, K_DONE);
        check_fb("clr_fb");

        // Colour, fill, clear-screen.
        rgb_model = 3'b010;
        send(8'h02, K_DONE);
        check("rgb_set", {29'd0, rgb}, 32'd2);
        send(8'h40, K_DONE);
        for (int c = 0; c < 16; c++) fb_model[c] = 8'hFF;
        check_fb("fill_fb");
        send(8'h30, K_DONE);
        for (int c = 0; c < 16; c++) fb_model[c] = 8'h00;
        check_fb("cls_fb");

        // One lit pixel so malformed commands have something to disturb.
        send(8'h10, K_NONE);
        send(8'h0C, K_NONE);
        fb_model[12] = 8'h80;
        send(8'h07, K_DONE);

        // Malformed commands.
        send(8'h10, K_NONE);
        send(8'h1A, K_ERR);
        check("bad_col_busy", {31'd0, busy}, 32'd0);
        send(8'h10, K_NONE);
        send(8'h03, K_NONE);
        send(8'h08, K_ERR);
        check("bad_row_busy", {31'd0, busy}, 32'd0);
        send(8'h77, K_ERR);
        check("bad_op_busy", {31'd0, busy}, 32'd0);
        check_fb("malformed_fb");
        drain("malformed_drain");

        // Resync mid-command, then the next byte is an opcode.
        rgb_model = 3'b101;
        send(8'h05, K_DONE);
        send(8'h10, K_NONE);
        send(8'hF5, K_NONE);
        check("resync_busy", {31'd0, busy}, 32'd0);
        rgb_model = 3'b010;
        send(8'h02, K_DONE);
        check("resync_rgb", {29'd0, rgb}, 32'd2);
        drain("resync_drain");

        // Opcode-looking bytes inside a command are data; re-setting a set pixel still completes.
        send(8'h10, K_NONE);
        send(8'h02, K_NONE);
        fb_model[2] = 8'h02;
        send(8'h01, K_DONE);
        send(8'h10, K_NONE);
        send(8'h02, K_NONE);
        send(8'h01, K_DONE);
        send(8'h20, K_NONE);
        send(8'h0C, K_NONE);
        send(8'h00, K_DONE);
        check_fb("data_bytes_fb");
        drain("data_bytes_drain");

        // Reset mid-command aborts with no pulse.
        send(8'h10, K_NONE);
        send(8'h04, K_NONE);
        check("mid_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset_mid_busy", {31'd0, busy}, 32'd0);
        check("reset_mid_rgb", {29'd0, rgb}, 32'd7);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        rgb_model = 3'b100;
        send(8'h04, K_DONE);
        check("post_reset_rgb", {29'd0, rgb}, 32'd4);
        check_fb("post_reset_fb");
        drain("reset_drain");

`ifdef LED_CMD_TIMEOUT_EN
        // 800 idle clocks after an opcode: timeout error.
        send(8'h10, K_NONE);
        begin
            exp_t e;
            e.is_err = 1'b1;
            e.rgb    = rgb_model;
            exp_q.push_back(e);
        end
        repeat (799) @(negedge clk);
        check("timeout_not_early", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("timeout_busy", {31'd0, busy}, 32'd0);
        drain("timeout_drain");

        // Byte on the expiry cycle wins.
        send(8'h10, K_NONE);
        repeat (798) @(negedge clk);
        send(8'h05, K_NONE);
        check("expiry_byte_busy", {31'd0, busy}, 32'd1);
        fb_model[5] = 8'h02;
        send(8'h01, K_DONE);
        check_fb("expiry_fb");
        drain("expiry_drain");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
